// File: rtl/wbs_charlie_frame.sv
// wbs_charlie_frame: Wishbone B4 pipelined slave driving a 7-pin charlieplexed
// display (42 LEDs). The bus writes seven 7-bit row masks into a shadow buffer
// and requests a swap. The swap copies shadow to active at the next frame
// boundary, so a frame is never shown half-updated. A scan engine walks rows
// 0..6, with an all-off blanking gap before each row.
//
// Ports
//   wbs_clk_i    single clock for bus and scan
//   wbs_rst_i    asynchronous, active-high reset
//   wbs_cyc_i    bus cycle valid
//   wbs_stb_i    request strobe
//   wbs_we_i     1 = write, 0 = read
//   wbs_adr_i    word address: 0..6 shadow rows, 7 ctrl/status, 8..15 unused
//   wbs_dat_i    write data, bits [6:0] used
//   wbs_dat_o    read data, valid with ack
//   wbs_stall_o  always 0
//   wbs_ack_o    one-cycle acknowledge, one cycle after each accepted request
//   charlie_o    pad output levels
//   charlie_oe   pad output enables (0 = high-Z)
module wbs_charlie_frame #(
  parameter int unsigned WB_CLK_HZ    = 48_000_000,
  parameter int unsigned REFRESH_HZ   = 100,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        wbs_clk_i,
  input  logic        wbs_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_stall_o,
  output logic        wbs_ack_o,
  output logic [6:0]  charlie_o,
  output logic [6:0]  charlie_oe
);

  localparam int unsigned NUM_ROWS   = 7;
  localparam int unsigned ROW_CYCLES = WB_CLK_HZ / (REFRESH_HZ * NUM_ROWS);
  localparam int unsigned DWELL      = (ROW_CYCLES > BLANK_CYCLES) ?
                                       (ROW_CYCLES - BLANK_CYCLES) : 0;
  localparam int unsigned CNT_MAX    = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned ROW_W      = 3;
  localparam logic [3:0]  ADR_CTRL   = 4'd7;

  // Refuse to build a display with no visible dwell time or no blanking gap.
  if (DWELL < 1 || BLANK_CYCLES < 1) begin : g_bad_timing
    $error("wbs_charlie_frame: need DWELL >= 1 and BLANK_CYCLES >= 1");
  end

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              frame_end_c;
  logic              swap_now_c;

  logic [6:0]        shadow_q [NUM_ROWS];
  logic [6:0]        active_q [NUM_ROWS];
  logic              swap_pending_q;

  logic [6:0]        pad_o_d, pad_oe_d;

  logic              accept_c, wr_c, rd_c;
  logic [31:0]       rd_data_c;
  logic              unused_dat_c;

  assign wbs_stall_o  = 1'b0;
  assign unused_dat_c = ^wbs_dat_i[31:7];

  // Scan state register.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Next-state: BLANK for BLANK_CYCLES, then SCAN for DWELL, then next row.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    row_d       = row_q;
    frame_end_c = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (row_q == ROW_W'(NUM_ROWS - 1)) begin
            row_d       = '0;
            frame_end_c = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  assign swap_now_c = frame_end_c & swap_pending_q;

  // Pad outputs for the upcoming state; registered below so pads track state exactly.
  // A swap only happens on the edge into BLANK, so the pre-swap active rows suffice here.
  always_comb begin
    pad_o_d  = '0;
    pad_oe_d = '0;
    if (state_d == ST_SCAN) begin
      pad_o_d  = 7'(1) << row_d;
      pad_oe_d = active_q[row_d] | pad_o_d;
    end
  end

  // Pad registers.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      charlie_o  <= '0;
      charlie_oe <= '0;
    end else begin
      charlie_o  <= pad_o_d;
      charlie_oe <= pad_oe_d;
    end
  end

  assign accept_c = wbs_cyc_i & wbs_stb_i;
  assign wr_c     = accept_c & wbs_we_i;
  assign rd_c     = accept_c & ~wbs_we_i;

  // Read mux; status word is {row[6:4], swap_pending[0]}.
  always_comb begin
    rd_data_c = '0;
    if (wbs_adr_i < ADR_CTRL) begin
      rd_data_c[6:0] = shadow_q[wbs_adr_i[2:0]];
    end else if (wbs_adr_i == ADR_CTRL) begin
      rd_data_c[6:4] = row_q;
      rd_data_c[0]   = swap_pending_q;
    end
  end

  // Bus response, shadow/active buffers and swap request.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      swap_pending_q <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      wbs_ack_o <= accept_c;
      wbs_dat_o <= rd_c ? rd_data_c : '0;
      // Copy uses pre-edge shadow, so a same-edge row write lands next frame.
      if (swap_now_c) begin
        for (int i = 0; i < NUM_ROWS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (wr_c && (wbs_adr_i < ADR_CTRL)) begin
        shadow_q[wbs_adr_i[2:0]] <= wbs_dat_i[6:0];
      end
      // A new request on the boundary edge wins over the clear.
      if (wr_c && (wbs_adr_i == ADR_CTRL) && wbs_dat_i[0]) begin
        swap_pending_q <= 1'b1;
      end else if (swap_now_c) begin
        swap_pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wbs_charlie_frame.sv
// Bench for wbs_charlie_frame with small timing parameters (row = 10 cycles,
// blank = 2, dwell = 8, frame = 70). A frame-position model tracks the
// number of clock edges since reset and derives the pads from it.
module tb_wbs_charlie_frame;

  localparam int unsigned CLK_HZ = 700;
  localparam int unsigned REF_HZ = 10;
  localparam int unsigned BLANK  = 2;
  localparam int          ROW    = 10;
  localparam int          FRAME  = 70;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  adr = '0;
  logic [31:0] dat_w = '0;
  logic [31:0] dat_r;
  logic        stall;
  logic        ack;
  logic [6:0]  pad_o;
  logic [6:0]  pad_oe;

  always #5 clk = ~clk;

  wbs_charlie_frame #(
    .WB_CLK_HZ   (CLK_HZ),
    .REFRESH_HZ  (REF_HZ),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .wbs_clk_i  (clk),
    .wbs_rst_i  (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_w),
    .wbs_dat_o  (dat_r),
    .wbs_stall_o(stall),
    .wbs_ack_o  (ack),
    .charlie_o  (pad_o),
    .charlie_oe (pad_oe)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [6:0]  m_shadow [7];
  logic [6:0]  m_active [7];
  logic        m_pending;
  int          m_t;
  logic        m_ack;
  logic [31:0] m_dat;

  typedef struct {
    logic        c, s, w;
    logic [3:0]  a;
    logic [31:0] d;
    logic        e_ack;
    logic [31:0] e_dat;
    logic        chk_dat;
  } vec_t;

  vec_t tab [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 1'b0;
    m_t       = 0;
    m_ack     = 1'b0;
    m_dat     = '0;
  endtask

  // One clock edge of the model: respond from pre-edge state, then advance.
  task automatic model_edge(input logic c, input logic s, input logic w,
                            input logic [3:0] a, input logic [31:0] d);
    logic acc;
    int   ai;
    acc   = c && s;
    ai    = int'(a);
    m_ack = acc;
    m_dat = '0;
    if (acc && !w) begin
      if (ai < 7) m_dat = {25'b0, m_shadow[ai]};
      else if (ai == 7) m_dat = {25'b0, 3'((m_t / ROW) % 7), 3'b0, m_pending};
    end
    m_t++;
    if ((m_t % FRAME) == 0 && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (acc && w) begin
      if (ai < 7) m_shadow[ai] = d[6:0];
      else if (ai == 7 && d[0]) m_pending = 1'b1;
    end
  endtask

  function automatic logic [6:0] exp_oe();
    int k;
    int r;
    k = m_t % ROW;
    r = (m_t / ROW) % 7;
    if (k < int'(BLANK)) return '0;
    return m_active[r] | (7'(1) << r);
  endfunction

  function automatic logic [6:0] exp_o();
    int k;
    int r;
    k = m_t % ROW;
    r = (m_t / ROW) % 7;
    if (k < int'(BLANK)) return '0;
    return 7'(1) << r;
  endfunction

  task automatic cycle(input logic c, input logic s, input logic w,
                       input logic [3:0] a, input logic [31:0] d);
    cyc = c; stb = s; we = w; adr = a; dat_w = d;
    model_edge(c, s, w, a, d);
    @(posedge clk);
    #1;
    chk("ack",   {31'b0, ack},   {31'b0, m_ack});
    chk("dat",   dat_r,          m_dat);
    chk("oe",    {25'b0, pad_oe}, {25'b0, exp_oe()});
    chk("o",     {25'b0, pad_o},  {25'b0, exp_o()});
    chk("stall", {31'b0, stall}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(1'b1, 1'b1, 1'b0, a, 32'd0);
  endtask

  // Idle until the model sits at the given position within the frame.
  task automatic run_to(input int ph);
    int guard;
    guard = 0;
    while ((m_t % FRAME) != ph && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL run_to: phase %0d not reached", ph);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic s, input logic w,
                              input logic [3:0] a, input logic [31:0] d,
                              input logic e_ack, input logic [31:0] e_dat,
                              input logic chk_dat);
    vec_t v;
    v.c = c; v.s = s; v.w = w; v.a = a; v.d = d;
    v.e_ack = e_ack; v.e_dat = e_dat; v.chk_dat = chk_dat;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rowval [7];
    logic       rc, rs, rw;
    logic [3:0] ra;
    logic [31:0] rdat;

    rowval[0] = 7'h05; rowval[1] = 7'h18; rowval[2] = 7'h2B; rowval[3] = 7'h3E;
    rowval[4] = 7'h51; rowval[5] = 7'h64; rowval[6] = 7'h77;

    // Back-to-back table: writes, reads, status, unmapped address, idle.
    for (int i = 0; i < 7; i++)
      tab.push_back(mk(1'b1, 1'b1, 1'b1, 4'(i), {25'h1FFFFFF, rowval[i]}, 1'b1, 32'd0, 1'b1));
    for (int i = 0; i < 7; i++)
      tab.push_back(mk(1'b1, 1'b1, 1'b0, 4'(i), 32'd0, 1'b1, {25'b0, rowval[i]}, 1'b1));
    tab.push_back(mk(1'b1, 1'b1, 1'b0, 4'd7,  32'd0,        1'b1, 32'd0, 1'b0));
    tab.push_back(mk(1'b1, 1'b1, 1'b1, 4'd12, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1));
    tab.push_back(mk(1'b1, 1'b1, 1'b0, 4'd12, 32'd0,        1'b1, 32'd0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0,  32'd0,        1'b0, 32'd0, 1'b1));
    tab.push_back(mk(1'b1, 1'b0, 1'b1, 4'd7,  32'd1,        1'b0, 32'd0, 1'b1));

    // Reset state
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_oe",  {25'b0, pad_oe}, 32'd0);
    chk("rst_o",   {25'b0, pad_o},  32'd0);
    chk("rst_ack", {31'b0, ack},    32'd0);
    chk("rst_dat", dat_r,           32'd0);
    rst = 1'b0;

    // 1: two blank cycles, then row 0 alone for 8 cycles
    idle(1);
    chk("t1_blank", {25'b0, pad_oe}, 32'd0);
    idle(1);
    chk("t1_row0_oe", {25'b0, pad_oe}, 32'h01);
    chk("t1_row0_o",  {25'b0, pad_o},  32'h01);
    idle(7);
    chk("t1_row0_end", {25'b0, pad_oe}, 32'h01);
    idle(1);
    chk("t1_blank2", {25'b0, pad_oe}, 32'd0);

    // 2: full row 0 mask then swap
    wr(4'd0, 32'h7F);
    wr(4'd7, 32'h1);
    run_to(0);
    idle(2);
    chk("t2_oe", {25'b0, pad_oe}, 32'h7F);
    chk("t2_o",  {25'b0, pad_o},  32'h01);
    rd(4'd7);
    chk("t2_status_bit0", dat_r & 32'd1, 32'd0);

    // 3: table of back-to-back transactions
    foreach (tab[i]) begin
      cycle(tab[i].c, tab[i].s, tab[i].w, tab[i].a, tab[i].d);
      chk($sformatf("tab%0d_ack", i), {31'b0, ack}, {31'b0, tab[i].e_ack});
      if (tab[i].chk_dat) chk($sformatf("tab%0d_dat", i), dat_r, tab[i].e_dat);
    end

    // 4: shadow write without swap leaves the display alone
    wr(4'd2, 32'h2A);
    idle(3 * FRAME);
    run_to(25);
    chk("t4_row2_oe", {25'b0, pad_oe}, 32'h04);
    rd(4'd2);
    chk("t4_rd2", dat_r, 32'h2A);

    // 5: boundary-edge shadow write, then boundary-edge swap request
    wr(4'd7, 32'h1);
    run_to(FRAME - 1);
    wr(4'd0, 32'h55);
    run_to(FRAME - 1);
    wr(4'd7, 32'h1);
    rd(4'd7);
    chk("t5_pending", dat_r & 32'd1, 32'd1);
    idle(1);
    chk("t5_row0_old", {25'b0, pad_oe}, 32'h05);
    idle(1);
    run_to(2);
    chk("t5_row0_new_oe", {25'b0, pad_oe}, 32'h55);
    chk("t5_row0_new_o",  {25'b0, pad_o},  32'h01);

    // 6: reset in the middle of row 4
    run_to(44);
    chk("t6_row4_oe", {25'b0, pad_oe}, 32'h51);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_oe", {25'b0, pad_oe}, 32'd0);
    chk("t6_async_o",  {25'b0, pad_o},  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("t6_hold_oe", {25'b0, pad_oe}, 32'd0);
    rst = 1'b0;
    idle(1);
    chk("t6_blank", {25'b0, pad_oe}, 32'd0);
    idle(1);
    chk("t6_row0_oe", {25'b0, pad_oe}, 32'h01);
    rd(4'd7);
    chk("t6_status", dat_r, 32'd0);
    rd(4'd4);
    chk("t6_shadow4", dat_r, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rc   = ($urandom_range(0, 3) != 0);
      rs   = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      ra   = ($urandom_range(0, 9) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
      rdat = $urandom;
      cycle(rc, rs, rw, ra, rdat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
